// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package regfile_scoreboard_pkg;
    localparam int TAG_WIDTH  = 4;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard_rf_array.sv
// 31x32 flop array with one write port and two asynchronous read ports; x0 is
// not stored and always reads zero.
module rf_array
    import regfile_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_we,
    input  reg_addr_t   i_waddr,
    input  logic [31:0] i_wdata,
    input  reg_addr_t   i_raddr_a,
    input  reg_addr_t   i_raddr_b,
    output logic [31:0] o_rdata_a,
    output logic [31:0] o_rdata_b
);
    logic [31:0]          r_mem [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]  w_wsel;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_wsel
            assign w_wsel[gi] = i_we && (i_waddr == reg_addr_t'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wsel[i]) r_mem[i] <= i_wdata;
            end
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? 32'd0 : r_mem[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? 32'd0 : r_mem[i_raddr_b];
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write scoreboard (dirty bit + writer tag).
// Optional same-cycle writeback bypass on the read ports: define RF_WR_BYPASS_EN.
module regfile_scoreboard #(
    parameter int TAG_WIDTH = regfile_scoreboard_pkg::TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set_dirty_en,
    input  logic [4:0]           set_dirty_addr,
    input  logic [TAG_WIDTH-1:0] set_dirty_tag,
    input  logic                 rf_wr_en,
    input  logic [TAG_WIDTH-1:0] rf_wr_tag,
    input  logic [4:0]           rf_wr_addr,
    input  logic [31:0]          rf_wr_data,
    input  logic                 clr_dirty_wb_en,
    input  logic [4:0]           clr_dirty_wb_addr,
    input  logic                 flush_dirty_all,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_data,
    output logic [31:0]          rs2_data,
    output logic                 rs1_dirty,
    output logic                 rs2_dirty,
    output logic                 rf_idle
);
    import regfile_scoreboard_pkg::*;

    logic [NUM_REGS-1:1]  r_dirty;
    logic [NUM_REGS-1:1]  w_dirty_next;
    logic [NUM_REGS-1:1]  w_tag_match;
    logic [NUM_REGS-1:1]  w_set_hit;
    logic [TAG_WIDTH-1:0] r_tag      [1:NUM_REGS-1];
    logic [TAG_WIDTH-1:0] w_tag_next [1:NUM_REGS-1];
    logic [NUM_REGS-1:0]  w_dirty_full;
    logic [31:0]          w_rs1_arr;
    logic [31:0]          w_rs2_arr;
    logic                 w_arr_we;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_sb
            logic w_commit_clr;
            logic w_wb_clr;
            assign w_set_hit[gi]   = set_dirty_en && (set_dirty_addr == reg_addr_t'(gi));
            assign w_tag_match[gi] = (r_tag[gi] == rf_wr_tag);
            assign w_commit_clr    = rf_wr_en && (rf_wr_addr == reg_addr_t'(gi)) && w_tag_match[gi];
            assign w_wb_clr        = clr_dirty_wb_en && (clr_dirty_wb_addr == reg_addr_t'(gi));
            // Global flush beats a new set, which beats any clear.
            assign w_dirty_next[gi] = flush_dirty_all ? 1'b0 :
                                      w_set_hit[gi]   ? 1'b1 :
                                      (w_commit_clr || w_wb_clr) ? 1'b0 : r_dirty[gi];
            assign w_tag_next[gi]   = (!flush_dirty_all && w_set_hit[gi]) ? set_dirty_tag : r_tag[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= '0;
            for (int i = 1; i < NUM_REGS; i++) r_tag[i] <= '0;
        end else begin
            r_dirty <= w_dirty_next;
            r_tag   <= w_tag_next;
        end
    end

    assign w_arr_we     = rf_wr_en && (rf_wr_addr != '0);
    assign w_dirty_full = {r_dirty, 1'b0};

    rf_array u_rf_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_we      (w_arr_we),
        .i_waddr   (rf_wr_addr),
        .i_wdata   (rf_wr_data),
        .i_raddr_a (rs1_addr),
        .i_raddr_b (rs2_addr),
        .o_rdata_a (w_rs1_arr),
        .o_rdata_b (w_rs2_arr)
    );

`ifdef RF_WR_BYPASS_EN
    logic [NUM_REGS-1:0] w_match_full;
    logic [NUM_REGS-1:0] w_set_full;
    logic                w_byp1;
    logic                w_byp2;

    assign w_match_full = {w_tag_match, 1'b0};
    assign w_set_full   = {w_set_hit, 1'b0};
    assign w_byp1       = w_arr_we && (rs1_addr == rf_wr_addr);
    assign w_byp2       = w_arr_we && (rs2_addr == rf_wr_addr);

    // A matching commit hides the stored dirty bit unless a new writer claims the register now.
    assign rs1_data  = w_byp1 ? rf_wr_data : w_rs1_arr;
    assign rs2_data  = w_byp2 ? rf_wr_data : w_rs2_arr;
    assign rs1_dirty = (w_byp1 && w_match_full[rs1_addr] && !w_set_full[rs1_addr]) ? 1'b0
                                                                                   : w_dirty_full[rs1_addr];
    assign rs2_dirty = (w_byp2 && w_match_full[rs2_addr] && !w_set_full[rs2_addr]) ? 1'b0
                                                                                   : w_dirty_full[rs2_addr];
`else
    assign rs1_data  = w_rs1_arr;
    assign rs2_data  = w_rs2_arr;
    assign rs1_dirty = w_dirty_full[rs1_addr];
    assign rs2_dirty = w_dirty_full[rs2_addr];
`endif

    assign rf_idle = ~|r_dirty;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard; honours RF_WR_BYPASS_EN when defined.
module tb_regfile_scoreboard;
`ifdef RF_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        set_dirty_en;
    logic [4:0]  set_dirty_addr;
    logic [3:0]  set_dirty_tag;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_tag;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic        clr_dirty_wb_en;
    logic [4:0]  clr_dirty_wb_addr;
    logic        flush_dirty_all;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_dirty;
    logic        rs2_dirty;
    logic        rf_idle;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] d1;
        logic        dy1;
        logic [31:0] d2;
        logic        dy2;
        logic        idle;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    regfile_scoreboard #(.TAG_WIDTH(4)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .set_dirty_en      (set_dirty_en),
        .set_dirty_addr    (set_dirty_addr),
        .set_dirty_tag     (set_dirty_tag),
        .rf_wr_en          (rf_wr_en),
        .rf_wr_tag         (rf_wr_tag),
        .rf_wr_addr        (rf_wr_addr),
        .rf_wr_data        (rf_wr_data),
        .clr_dirty_wb_en   (clr_dirty_wb_en),
        .clr_dirty_wb_addr (clr_dirty_wb_addr),
        .flush_dirty_all   (flush_dirty_all),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_data          (rs1_data),
        .rs2_data          (rs2_data),
        .rs1_dirty         (rs1_dirty),
        .rs2_dirty         (rs2_dirty),
        .rf_idle           (rf_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic s_en, input logic [4:0] s_addr, input logic [3:0] s_tag,
                       input logic w_en, input logic [4:0] w_addr, input logic [3:0] w_tag,
                       input logic [31:0] w_data, input logic c_en, input logic [4:0] c_addr,
                       input logic fl, input logic [4:0] a1, input logic [4:0] a2);
        set_dirty_en      = s_en;
        set_dirty_addr    = s_addr;
        set_dirty_tag     = s_tag;
        rf_wr_en          = w_en;
        rf_wr_addr        = w_addr;
        rf_wr_tag         = w_tag;
        rf_wr_data        = w_data;
        clr_dirty_wb_en   = c_en;
        clr_dirty_wb_addr = c_addr;
        flush_dirty_all   = fl;
        rs1_addr          = a1;
        rs2_addr          = a2;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2);
    endtask

    task automatic push(input string nm, input logic [31:0] d1, input logic dy1,
                        input logic [31:0] d2, input logic dy2, input logic idle);
        exp_t e;
        e.d1 = d1; e.dy1 = dy1; e.d2 = d2; e.dy2 = dy2; e.idle = idle;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk();
        exp_t  e;
        string nm;
        #2;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compared += 5;
        assert (rs1_data === e.d1) else begin
            mismatched++;
            $error("FAIL %s rs1_data got %h exp %h", nm, rs1_data, e.d1);
        end
        assert (rs1_dirty === e.dy1) else begin
            mismatched++;
            $error("FAIL %s rs1_dirty got %b exp %b", nm, rs1_dirty, e.dy1);
        end
        assert (rs2_data === e.d2) else begin
            mismatched++;
            $error("FAIL %s rs2_data got %h exp %h", nm, rs2_data, e.d2);
        end
        assert (rs2_dirty === e.dy2) else begin
            mismatched++;
            $error("FAIL %s rs2_dirty got %b exp %b", nm, rs2_dirty, e.dy2);
        end
        assert (rf_idle === e.idle) else begin
            mismatched++;
            $error("FAIL %s rf_idle got %b exp %b", nm, rf_idle, e.idle);
        end
        $display("txn %-16s rs1=%h/%b rs2=%h/%b idle=%b", nm, rs1_data, rs1_dirty, rs2_data, rs2_dirty, rf_idle);
    endtask

    initial begin
        reset_n = 1'b0;
        rd(5, 0);
        push("reset_active", 0, 0, 0, 0, 1); #1; chk();
        @(negedge clk);
        reset_n = 1'b1;
        tick(); rd(5, 0);
        push("reset_read", 0, 0, 0, 0, 1); chk();

        // x5: set tag 3 then matching commit
        tick(); drv(1, 5, 3, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        push("x5_set", 0, 0, 0, 0, 1); chk();
        tick(); drv(0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        push("x5_commit", BYP ? 32'hDEADBEEF : 32'h0, BYP ? 1'b0 : 1'b1, 0, 0, 0); chk();
        tick(); rd(5, 0);
        push("x5_after", 32'hDEADBEEF, 0, 0, 0, 1); chk();

        // x7: two writers, stale commit then current commit
        tick(); drv(1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 7, 5);
        push("x7_set2", 0, 0, 32'hDEADBEEF, 0, 1); chk();
        tick(); drv(1, 7, 4, 0, 0, 0, 0, 0, 0, 0, 7, 5);
        push("x7_set4", 0, 1, 32'hDEADBEEF, 0, 0); chk();
        tick(); drv(0, 0, 0, 1, 7, 2, 32'h11, 0, 0, 0, 7, 5);
        push("x7_stale_cmt", BYP ? 32'h11 : 32'h0, 1, 32'hDEADBEEF, 0, 0); chk();
        tick(); rd(7, 5);
        push("x7_stale_after", 32'h11, 1, 32'hDEADBEEF, 0, 0); chk();
        tick(); drv(0, 0, 0, 1, 7, 4, 32'h22, 0, 0, 0, 7, 5);
        push("x7_cur_cmt", BYP ? 32'h22 : 32'h11, BYP ? 1'b0 : 1'b1, 32'hDEADBEEF, 0, 0); chk();
        tick(); rd(7, 5);
        push("x7_cur_after", 32'h22, 0, 32'hDEADBEEF, 0, 1); chk();

        // x9: same-cycle set (tag 1) and commit with old tag 0
        tick(); drv(1, 9, 1, 1, 9, 0, 32'h99, 0, 0, 0, 9, 0);
        push("x9_set_cmt", BYP ? 32'h99 : 32'h0, 0, 0, 0, 1); chk();
        tick(); rd(9, 0);
        push("x9_after", 32'h99, 1, 0, 0, 0); chk();
        tick(); drv(0, 0, 0, 1, 9, 1, 32'h9A, 0, 0, 0, 9, 0);
        push("x9_tag1_cmt", BYP ? 32'h9A : 32'h99, BYP ? 1'b0 : 1'b1, 0, 0, 0); chk();
        tick(); rd(9, 0);
        push("x9_tag1_after", 32'h9A, 0, 0, 0, 1); chk();

        // flush_dirty_all drops a simultaneous set
        tick(); drv(1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        push("x3_set", 0, 0, 0, 0, 1); chk();
        tick(); drv(1, 4, 6, 0, 0, 0, 0, 0, 0, 0, 3, 4);
        push("x4_set", 0, 1, 0, 0, 0); chk();
        tick(); drv(1, 6, 7, 0, 0, 0, 0, 0, 0, 1, 4, 6);
        push("flush_set6", 0, 1, 0, 0, 0); chk();
        tick(); rd(3, 6);
        push("flush_after", 0, 0, 0, 0, 1); chk();
        tick(); rd(4, 6);
        push("flush_x4", 0, 0, 0, 0, 1); chk();

        // writeback clear releases x3 without touching its data
        tick(); drv(0, 0, 0, 1, 3, 5, 32'h33, 0, 0, 0, 4, 0);
        push("x3_write", 0, 0, 0, 0, 1); chk();
        tick(); drv(1, 3, 8, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        push("x3_set8", 32'h33, 0, 0, 0, 1); chk();
        tick(); drv(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0);
        push("x3_wbclr", 32'h33, 1, 0, 0, 0); chk();
        tick(); rd(3, 0);
        push("x3_wbclr_after", 32'h33, 0, 0, 0, 1); chk();

        // x0 ignores writes and sets
        tick(); drv(1, 0, 1, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        push("x0_wr_set", 0, 0, 0, 0, 1); chk();
        tick(); rd(0, 0);
        push("x0_after", 0, 0, 0, 0, 1); chk();

        // x8 commit while reading it
        tick(); drv(0, 0, 0, 1, 8, 0, 32'h55, 0, 0, 0, 8, 0);
        push("x8_commit", BYP ? 32'h55 : 32'h0, 0, 0, 0, 1); chk();
        tick(); rd(8, 0);
        push("x8_after", 32'h55, 0, 0, 0, 1); chk();

        // asynchronous reset mid-operation
        tick(); drv(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 10, 5);
        push("x10_set", 0, 0, 32'hDEADBEEF, 0, 1); chk();
        tick(); rd(10, 5);
        push("x10_dirty", 0, 1, 32'hDEADBEEF, 0, 0); chk();
        #1 reset_n = 1'b0;
        push("async_reset", 0, 0, 0, 0, 1); chk();

        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain left %0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Integer register file with per-register pending-write scoreboard. It is the receiving end of the writeback interface: it consumes `rf_wr_*` and `clr_dirty_wb_*` from the writeback stage. It also accepts dirty-set requests from decode/issue and serves two combinational read ports with per-operand dirty flags for hazard detection.

## Interface
Parameters:
- `TAG_WIDTH`, default 4: width of the writer tag stored per register; must match the shared package constant.

Ports:
- `clk` input 1: core clock; single clock domain.
- `reset_n` input 1: asynchronous, active-low reset.
- `set_dirty_en` input 1: issue marks a destination register as pending.
- `set_dirty_addr` input 5: destination register index.
- `set_dirty_tag` input TAG_WIDTH: tag of the issuing instruction.
- `rf_wr_en` input 1: writeback commit strobe.
- `rf_wr_tag` input TAG_WIDTH: tag of the committing instruction.
- `rf_wr_addr` input 5: committed register index.
- `rf_wr_data` input 32: committed data.
- `clr_dirty_wb_en` input 1: flushed instruction reached writeback; release its pending mark.
- `clr_dirty_wb_addr` input 5: register to release.
- `flush_dirty_all` input 1: pipeline-wide flush; clears every dirty bit.
- `rs1_addr`, `rs2_addr` input 5 each: read indices.
- `rs1_data`, `rs2_data` output 32 each: read data.
- `rs1_dirty`, `rs2_dirty` output 1 each: operand has an outstanding writer.
- `rf_idle` output 1: no register is dirty.

## Operation
- State: `regs[1:31]` (32 b each), `dirty[1:31]`, `tag[1:31]`. x0 is not stored, reads 0, is never dirty, and ignores all writes, sets and clears.
- Write: on `rf_wr_en` with addr≠0, `regs[addr]` ← `rf_wr_data` at the clock edge, regardless of tag.
- Commit clear: on `rf_wr_en`, `dirty[addr]` ← 0 only if `tag[addr]` == `rf_wr_tag`. On a mismatch a younger writer is pending and dirty stays 1.
- Flush clear: on `clr_dirty_wb_en`, `dirty[addr]` ← 0 unconditionally. No data is written.
- Set: on `set_dirty_en`, `dirty[addr]` ← 1 and `tag[addr]` ← `set_dirty_tag`.
- Priority for the same register in the same cycle: `flush_dirty_all` > set > commit clear / flush clear.
  - Set plus commit on the same address: data is written, dirty stays 1, and the new tag is installed.
  - `flush_dirty_all` with a simultaneous set: the set is dropped.
- Events on different addresses in one cycle all take effect independently.
- Reads are combinational from the array. `rf_idle` = ~|dirty.

## Timing
- Reset: all `regs` = 0, `dirty` = 0, `tag` = 0. As a result `rs*_data` = 0, `rs*_dirty` = 0 and `rf_idle` = 1 during and after reset.
- Reset asserted mid-operation discards all pending marks immediately (asynchronous clear).
- Write latency: data and dirty updates are visible on read ports the cycle after the strobe. With the bypass option below, writes are visible in the same cycle.
- A set is visible as `rs*_dirty` = 1 in the cycle after `set_dirty_en`. Sets are never bypassed.
- No handshake; every strobe is single-cycle and is always accepted.

## Configuration
- `RF_WR_BYPASS_EN` defined: a read port whose address equals `rf_wr_addr` (≠0) while `rf_wr_en` = 1 behaves as follows:
  - returns `rf_wr_data` in the same cycle;
  - reports dirty = 0 if `tag[addr]` == `rf_wr_tag` and no same-cycle set hits that address; otherwise it reports the stored dirty bit.
- Undefined: read ports show only registered state, i.e. one extra cycle of hazard stall after commit.

## Structure
- Shared package holds `TAG_WIDTH`, the register-count constant (32), and the `reg_addr_t` (5-bit) typedef.
- One sub-module, `rf_array`: a 31×32 flop array with one write port and two asynchronous read ports, x0 hardwired to zero. Scoreboard logic and bypass live in `regfile_scoreboard`.

## Test plan
- Reset, then read rs1 = 5 and rs2 = 0 -> both data 0, both dirty 0, `rf_idle` = 1.
- Set x5 with tag 3, next cycle commit x5 with data 0xDEADBEEF and tag 3 -> dirty 1 for one cycle, then rs1 = 5 reads 0xDEADBEEF with dirty 0 and `rf_idle` = 1.
- Set x7 with tag 2, then set x7 with tag 4, then commit x7 with tag 2 and data 0x11 -> x7 reads 0x11 and remains dirty; a later commit with tag 4 and data 0x22 clears dirty and reads 0x22.
- Same-cycle set of x9 with tag 1 and commit of x9 with matching old tag -> data written, dirty 1, tag 1.
- Dirty x3 and x4, then pulse `flush_dirty_all` together with a set of x6 -> next cycle all dirty 0, `rf_idle` = 1, x6 not dirty. Separately, `clr_dirty_wb_en` on x3 leaves x3's data unchanged.
- Commit x0 with data 0xFFFFFFFF plus a set of x0 -> x0 reads 0 and is never dirty. With `RF_WR_BYPASS_EN`, commit x8 with data 0x55 while reading x8 -> the same cycle returns 0x55.
